// File: rtl/spi_cmd_engine.sv
// rtl/spi_cmd_engine.sv - decodes 32-bit bridge words into core commands and returns core responses
module spi_cmd_engine #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TIMEOUT_W      = 11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_fifo_empty,
  output logic        bus_read,
  input  logic        bus_read_response,
  input  logic [31:0] bus_read_data,
  output logic        bus_write,
  input  logic        bus_write_response,
  output logic [31:0] bus_write_data,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [7:0]  cmd_opcode,
  output logic [23:0] cmd_arg,
  output logic [31:0] cmd_operand,
  output logic        cmd_has_operand,
  input  logic        rsp_valid,
  output logic        rsp_ready,
  input  logic [31:0] rsp_data,
  output logic        err_timeout,
  output logic        busy
);

  typedef enum logic [3:0] {
    IDLE, CMD_WAIT, CMD_DRAIN, OP_WAIT, OP_DRAIN, ISSUE, RSP_WAIT, WR_WAIT, WR_DRAIN
  } state_t;

  localparam logic [TIMEOUT_W-1:0] TIMER_MAX = TIMEOUT_W'(TIMEOUT_CYCLES);

  state_t               state;
  state_t               state_next;
  logic                 rd_q;
  logic                 wr_q;
  logic                 rd_edge;
  logic                 wr_edge;
  logic [TIMEOUT_W-1:0] timer;
  logic                 timed_out;
  logic                 read_next;
  logic                 write_next;
  logic                 cap_cmd;
  logic                 cap_op;
  logic                 cap_rsp;
  logic                 timer_clr;

  // A bridge response may be held for several cycles; only its rising edge counts.
  assign rd_edge         = bus_read_response & ~rd_q;
  assign wr_edge         = bus_write_response & ~wr_q;
  assign timed_out       = (timer == TIMER_MAX);
  assign cmd_has_operand = cmd_opcode[7];
  assign busy            = (state != IDLE);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next state, combinational handshake outputs and per-transition strobes.
  always_comb begin
    state_next  = state;
    read_next   = 1'b0;
    write_next  = 1'b0;
    cap_cmd     = 1'b0;
    cap_op      = 1'b0;
    cap_rsp     = 1'b0;
    timer_clr   = 1'b0;
    cmd_valid   = 1'b0;
    rsp_ready   = 1'b0;
    err_timeout = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_fifo_empty) begin
          read_next  = 1'b1;
          state_next = CMD_WAIT;
        end
      end
      CMD_WAIT: begin
        if (rd_edge) begin
          cap_cmd    = 1'b1;
          state_next = CMD_DRAIN;
        end
      end
      CMD_DRAIN: begin
        if (!bus_read_response) begin
          if (cmd_opcode[7]) begin
            read_next  = 1'b1;
            timer_clr  = 1'b1;
            state_next = OP_WAIT;
          end else begin
            state_next = ISSUE;
          end
        end
      end
      OP_WAIT: begin
        if (rd_edge) begin
          cap_op     = 1'b1;
          state_next = OP_DRAIN;
        end else if (timed_out) begin
          err_timeout = 1'b1;
          state_next  = IDLE;
        end
      end
      OP_DRAIN: begin
        if (!bus_read_response) state_next = ISSUE;
      end
      ISSUE: begin
        cmd_valid = 1'b1;
        if (cmd_ready) state_next = cmd_opcode[6] ? RSP_WAIT : IDLE;
      end
      RSP_WAIT: begin
        if (rsp_valid) begin
          rsp_ready  = 1'b1;
          cap_rsp    = 1'b1;
          write_next = 1'b1;
          state_next = WR_WAIT;
        end
      end
      WR_WAIT: begin
        if (wr_edge) state_next = WR_DRAIN;
      end
      WR_DRAIN: begin
        if (!bus_write_response) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Response edge history and one-cycle bus request pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      bus_read  <= 1'b0;
      bus_write <= 1'b0;
    end else begin
      rd_q      <= bus_read_response;
      wr_q      <= bus_write_response;
      bus_read  <= read_next;
      bus_write <= write_next;
    end
  end

  // Operand timer: restarts on entry to OP_WAIT and saturates at the limit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer <= '0;
    end else if (timer_clr) begin
      timer <= '0;
    end else if (state == OP_WAIT && !timed_out) begin
      timer <= timer + TIMEOUT_W'(1);
    end
  end

  // Captured command fields and outgoing response word; held until the next capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmd_opcode     <= '0;
      cmd_arg        <= '0;
      cmd_operand    <= '0;
      bus_write_data <= '0;
    end else begin
      if (cap_cmd) begin
        cmd_opcode  <= bus_read_data[31:24];
        cmd_arg     <= bus_read_data[23:0];
        cmd_operand <= '0;
      end
      if (cap_op)  cmd_operand    <= bus_read_data;
      if (cap_rsp) bus_write_data <= rsp_data;
    end
  end

endmodule

// File: tb/tb_spi_cmd_engine.sv
// tb/tb_spi_cmd_engine.sv - randomized self-checking bench for spi_cmd_engine
module tb_spi_cmd_engine;
  localparam int TO = 16;

  typedef struct {
    logic [7:0]  op;
    logic [23:0] arg;
    logic [31:0] operand;
    logic        has_op;
  } cmd_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_fifo_empty, bus_read, bus_read_response;
  logic [31:0] bus_read_data;
  logic        bus_write, bus_write_response;
  logic [31:0] bus_write_data;
  logic        cmd_valid, cmd_ready, cmd_has_operand;
  logic [7:0]  cmd_opcode;
  logic [23:0] cmd_arg;
  logic [31:0] cmd_operand;
  logic        rsp_valid, rsp_ready, err_timeout, busy;
  logic [31:0] rsp_data;

  always #5 clk = ~clk;

  spi_cmd_engine #(.TIMEOUT_CYCLES(TO), .TIMEOUT_W(5)) dut (
    .clk(clk), .reset(reset), .rx_fifo_empty(rx_fifo_empty),
    .bus_read(bus_read), .bus_read_response(bus_read_response), .bus_read_data(bus_read_data),
    .bus_write(bus_write), .bus_write_response(bus_write_response), .bus_write_data(bus_write_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode), .cmd_arg(cmd_arg),
    .cmd_operand(cmd_operand), .cmd_has_operand(cmd_has_operand),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .err_timeout(err_timeout), .busy(busy)
  );

  int compared = 0, mismatched = 0;
  logic [31:0] rd_words[$];
  cmd_t        exp_cmds[$], obs_cmds[$];
  logic [31:0] exp_wr[$], obs_wr[$];
  int          rd_cycles[$], hs_cycles[$];
  int  rd_delay_cfg = -1, rd_hold_cfg = -1, ready_delay = 0, exp_nwr = 0;
  bit  wr_mute = 1'b0, rsp_force_en = 1'b0;
  logic [31:0] rsp_force = '0;
  int  cyc = 0, n_rd = 0, n_wr = 0, n_rsp_rdy = 0, n_err = 0, n_hs = 0, n_valid = 0, pend = 0;
  int  rd_wide = 0, wr_unstable = 0, fld_unstable = 0, t_err = 0, t_valid = 0, t_rresp = 0;

  // Bridge read side: answers each bus_read with the next queued word.
  initial begin
    int d, h;
    logic [31:0] w;
    bus_read_response = 1'b0;
    bus_read_data     = '0;
    rx_fifo_empty     = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (bus_read && rd_words.size() > 0) begin
        w = rd_words.pop_front();
        rx_fifo_empty = (rd_words.size() == 0);
        d = (rd_delay_cfg < 0) ? int'($urandom_range(0, 3)) : rd_delay_cfg;
        h = (rd_hold_cfg < 0) ? int'($urandom_range(1, 3)) : rd_hold_cfg;
        repeat (d) begin @(posedge clk); #1; end
        bus_read_data = w;
        bus_read_response = 1'b1;
        repeat (h) begin @(posedge clk); #1; end
        bus_read_response = 1'b0;
      end
    end
  end

  // Bridge write side.
  initial begin
    int d, h;
    bus_write_response = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (bus_write && !wr_mute) begin
        d = $urandom_range(0, 4);
        h = $urandom_range(1, 3);
        repeat (d) begin @(posedge clk); #1; end
        bus_write_response = 1'b1;
        repeat (h) begin @(posedge clk); #1; end
        bus_write_response = 1'b0;
      end
    end
  end

  // Core side: accepts commands after ready_delay cycles, answers response opcodes.
  initial begin
    int rcnt, rsp_seen, rsp_wait;
    rcnt = 0; rsp_seen = 0; rsp_wait = 0;
    cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0;
    forever begin
      @(posedge clk); #1;
      cmd_ready = 1'b0;
      if (cmd_valid) begin
        if (rcnt >= ready_delay) cmd_ready = 1'b1;
        else rcnt++;
      end else begin
        rcnt = 0;
      end
      if (rsp_valid && n_rsp_rdy != rsp_seen) begin
        rsp_valid = 1'b0;
        rsp_seen  = n_rsp_rdy;
      end else if (!rsp_valid && pend > 0) begin
        if (rsp_wait > 0) begin
          rsp_wait--;
        end else begin
          rsp_data  = rsp_force_en ? rsp_force : $urandom;
          rsp_valid = 1'b1;
          exp_wr.push_back(rsp_data);
          pend--;
          rsp_wait  = $urandom_range(0, 3);
        end
      end
    end
  end

  // Observer: records pulses, handshakes and stability on the falling edge.
  initial begin
    cmd_t mc;
    logic prev_rd, prev_valid, prev_rresp, wr_hold;
    logic [64:0] prev_fld;
    logic [31:0] wr_ref;
    prev_rd = 0; prev_valid = 0; prev_rresp = 0; wr_hold = 0; prev_fld = '0; wr_ref = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus_read) begin n_rd++; rd_cycles.push_back(cyc); end
      if (bus_read && prev_rd) rd_wide++;
      if (!reset) wr_hold = 1'b0;
      if (bus_write) begin
        n_wr++; obs_wr.push_back(bus_write_data); wr_hold = 1'b1; wr_ref = bus_write_data;
      end
      if (wr_hold) begin
        if (bus_write_data !== wr_ref) wr_unstable++;
        if (bus_write_response) wr_hold = 1'b0;
      end
      if (rsp_ready) n_rsp_rdy++;
      if (err_timeout) begin n_err++; t_err = cyc; end
      if (cmd_valid) n_valid++;
      if (cmd_valid && !prev_valid) t_valid = cyc;
      if (cmd_valid && prev_valid &&
          {cmd_opcode, cmd_arg, cmd_operand, cmd_has_operand} !== prev_fld) fld_unstable++;
      if (bus_read_response && !prev_rresp) t_rresp = cyc;
      if (cmd_valid && cmd_ready) begin
        n_hs++; hs_cycles.push_back(cyc);
        mc.op = cmd_opcode; mc.arg = cmd_arg; mc.operand = cmd_operand; mc.has_op = cmd_has_operand;
        obs_cmds.push_back(mc);
        if (cmd_opcode[6]) pend++;
      end
      prev_rd = bus_read; prev_valid = cmd_valid; prev_rresp = bus_read_response;
      prev_fld = {cmd_opcode, cmd_arg, cmd_operand, cmd_has_operand};
    end
  end

  // Reference model: what a queued command word (and operand) must decode to.
  task automatic push_cmd(input logic [31:0] w, input logic [31:0] opnd);
    cmd_t c;
    rd_words.push_back(w);
    if (w[31]) rd_words.push_back(opnd);
    c.op = w[31:24]; c.arg = w[23:0]; c.has_op = w[31];
    c.operand = w[31] ? opnd : 32'h0;
    exp_cmds.push_back(c);
    if (w[30]) exp_nwr++;
    rx_fifo_empty = 1'b0;
  endtask

  task automatic clear_obs;
    obs_cmds.delete(); exp_cmds.delete(); obs_wr.delete(); exp_wr.delete();
    rd_cycles.delete(); hs_cycles.delete(); exp_nwr = 0;
    rd_wide = 0; wr_unstable = 0; fld_unstable = 0;
  endtask

  task automatic wait_idle(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (!busy && rd_words.size() == 0 && pend == 0 && !rsp_valid &&
          !bus_read_response && !bus_write_response) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    compared++;
    if ({bus_read, bus_write, bus_write_data, cmd_valid, cmd_opcode, cmd_arg, cmd_operand,
         cmd_has_operand, rsp_ready, err_timeout, busy} !== '0) begin
      mismatched++; $display("FAIL reset_outputs: some output nonzero, busy=%b cmd_valid=%b", busy, cmd_valid);
    end
    @(posedge clk); #1; reset = 1'b1;
    repeat (2) @(negedge clk);
    compared++;
    if (busy !== 1'b0 || bus_read !== 1'b0) begin
      mismatched++; $display("FAIL reset_idle: busy=%b bus_read=%b want 0 0", busy, bus_read);
    end
  endtask

  task automatic test_no_operand;
    bit ok;
    int r0, w0, h0;
    clear_obs; rd_delay_cfg = 0; rd_hold_cfg = 2;
    r0 = n_rd; w0 = n_wr; h0 = n_hs;
    @(posedge clk); #1;
    push_cmd(32'h01ABCDEF, 32'h0);
    wait_idle(200, ok);
    compared++;
    if (!ok) begin mismatched++; $display("FAIL plain_idle: engine still busy=%b", busy); end
    compared++;
    if (n_rd - r0 != 1 || n_hs - h0 != 1 || n_wr - w0 != 0) begin
      mismatched++; $display("FAIL plain_counts: reads=%0d hs=%0d writes=%0d want 1 1 0", n_rd - r0, n_hs - h0, n_wr - w0);
    end
    compared++;
    if (obs_cmds.size() != 1 || obs_cmds[0] != exp_cmds[0]) begin
      mismatched++; $display("FAIL plain_decode: got %0d cmds op=%h want op=01 arg=ABCDEF operand=0",
                             obs_cmds.size(), cmd_opcode);
    end
    compared++;
    if (t_valid - t_rresp != 2 + (rd_hold_cfg - 1)) begin
      mismatched++; $display("FAIL plain_latency: got %0d cycles want %0d", t_valid - t_rresp, 2 + (rd_hold_cfg - 1));
    end
  endtask

  task automatic test_operand;
    bit ok;
    int r0;
    clear_obs; rd_delay_cfg = -1; rd_hold_cfg = -1;
    r0 = n_rd;
    @(posedge clk); #1;
    push_cmd(32'h80000010, 32'hDEADBEEF);
    wait_idle(200, ok);
    compared++;
    if (!ok || n_rd - r0 != 2) begin
      mismatched++; $display("FAIL operand_reads: got %0d reads ok=%b want 2", n_rd - r0, ok);
    end
    compared++;
    if (obs_cmds.size() != 1 || obs_cmds[0].operand !== 32'hDEADBEEF || obs_cmds[0].has_op !== 1'b1) begin
      mismatched++; $display("FAIL operand_decode: operand=%h has=%b want DEADBEEF 1", cmd_operand, cmd_has_operand);
    end
    compared++;
    if (rd_wide != 0) begin mismatched++; $display("FAIL read_pulse_width: %0d wide pulses want 0", rd_wide); end
  endtask

  task automatic test_response;
    bit ok;
    int q0, w0;
    clear_obs; rsp_force_en = 1'b1; rsp_force = 32'h12345678;
    q0 = n_rsp_rdy; w0 = n_wr;
    @(posedge clk); #1;
    push_cmd({8'h40, 24'($urandom)}, 32'h0);
    wait_idle(300, ok);
    rsp_force_en = 1'b0;
    compared++;
    if (!ok || busy !== 1'b0) begin mismatched++; $display("FAIL rsp_idle: busy=%b ok=%b want 0 1", busy, ok); end
    compared++;
    if (n_rsp_rdy - q0 != 1 || n_wr - w0 != 1) begin
      mismatched++; $display("FAIL rsp_counts: rsp_ready=%0d writes=%0d want 1 1", n_rsp_rdy - q0, n_wr - w0);
    end
    compared++;
    if (obs_wr.size() != 1 || obs_wr[0] !== 32'h12345678 || wr_unstable != 0) begin
      mismatched++; $display("FAIL rsp_data: got %h unstable=%0d want 12345678 0", bus_write_data, wr_unstable);
    end
  endtask

  task automatic test_timeout;
    int e0, h0, v0, r0, busy_seen;
    bit got;
    clear_obs; e0 = n_err; h0 = n_hs; v0 = n_valid; got = 1'b0;
    @(posedge clk); #1;
    rd_words.push_back(32'h80000055);
    rx_fifo_empty = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (n_err != e0) begin got = 1'b1; break; end
    end
    compared++;
    if (!got) begin mismatched++; $display("FAIL timeout_fire: no err_timeout pulse seen"); end
    compared++;
    if (rd_cycles.size() != 2 || t_err - rd_cycles[1] != TO) begin
      mismatched++; $display("FAIL timeout_delay: reads=%0d delay=%0d want 2 %0d",
                             rd_cycles.size(), t_err - (rd_cycles.size() > 1 ? rd_cycles[1] : 0), TO);
    end
    repeat (3) @(negedge clk);
    compared++;
    if (n_err - e0 != 1 || n_valid != v0 || n_hs != h0) begin
      mismatched++; $display("FAIL timeout_once: errs=%0d valid_cycles=%0d want 1 0", n_err - e0, n_valid - v0);
    end
    r0 = n_rd; busy_seen = 0;
    @(posedge clk); #1;
    bus_read_data = 32'hCAFEF00D; bus_read_response = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    bus_read_response = 1'b0;
    for (int i = 0; i < 6; i++) begin @(negedge clk); if (busy) busy_seen++; end
    compared++;
    if (busy_seen != 0 || n_rd != r0 || n_hs != h0 || n_valid != v0) begin
      mismatched++; $display("FAIL late_response: busy_cycles=%0d reads=%0d want 0 0", busy_seen, n_rd - r0);
    end
  endtask

  task automatic test_backpressure;
    bit ok;
    int v0, h0;
    clear_obs; ready_delay = 20; v0 = n_valid; h0 = n_hs;
    @(posedge clk); #1;
    push_cmd({8'h2A, 24'($urandom)}, 32'h0);
    wait_idle(300, ok);
    ready_delay = 0;
    compared++;
    if (!ok || n_valid - v0 != 21 || n_hs - h0 != 1) begin
      mismatched++; $display("FAIL backpressure_hold: valid_cycles=%0d hs=%0d want 21 1", n_valid - v0, n_hs - h0);
    end
    compared++;
    if (fld_unstable != 0 || obs_cmds.size() != 1 || obs_cmds[0] != exp_cmds[0]) begin
      mismatched++; $display("FAIL backpressure_fields: unstable=%0d cmds=%0d want 0 1", fld_unstable, obs_cmds.size());
    end
  endtask

  task automatic test_reset_midop;
    bit ok;
    int w0;
    logic [31:0] opnd;
    clear_obs;
    @(posedge clk); #1;
    rd_words.push_back(32'h80000001);
    rx_fifo_empty = 1'b0;
    for (int i = 0; i < 100 && rd_cycles.size() < 2; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    compared++;
    if ({bus_read, bus_write, bus_write_data, cmd_valid, cmd_opcode, cmd_arg, cmd_operand,
         cmd_has_operand, rsp_ready, err_timeout, busy} !== '0 || rd_cycles.size() != 2) begin
      mismatched++; $display("FAIL reset_op_wait: busy=%b opcode=%h reads=%0d want 0 00 2", busy, cmd_opcode, rd_cycles.size());
    end
    repeat (2) @(posedge clk); #1; reset = 1'b1;
    clear_obs; wr_mute = 1'b1; w0 = n_wr;
    @(posedge clk); #1;
    push_cmd(32'h40000002, 32'h0);
    for (int i = 0; i < 200 && n_wr == w0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    compared++;
    if ({bus_read, bus_write, bus_write_data, cmd_valid, cmd_opcode, cmd_arg, cmd_operand,
         cmd_has_operand, rsp_ready, err_timeout, busy} !== '0 || n_wr == w0) begin
      mismatched++; $display("FAIL reset_wr_wait: busy=%b wdata=%h writes=%0d want 0 0 1", busy, bus_write_data, n_wr - w0);
    end
    repeat (2) @(posedge clk); #1; reset = 1'b1; wr_mute = 1'b0;
    clear_obs;
    opnd = $urandom;
    @(posedge clk); #1;
    push_cmd(32'h9C00BEEF, opnd);
    wait_idle(200, ok);
    compared++;
    if (!ok || obs_cmds.size() != 1 || obs_cmds[0] != exp_cmds[0]) begin
      mismatched++; $display("FAIL reset_recover: cmds=%0d operand=%h want 1 %h", obs_cmds.size(), cmd_operand, opnd);
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    clear_obs; rd_delay_cfg = 0; rd_hold_cfg = 1;
    @(posedge clk); #1;
    push_cmd(32'h05000111, 32'h0);
    push_cmd(32'h06000222, 32'h0);
    wait_idle(200, ok);
    rd_delay_cfg = -1; rd_hold_cfg = -1;
    compared++;
    if (!ok || hs_cycles.size() != 2 || rd_cycles.size() != 2 || rd_cycles[1] - hs_cycles[0] != 2) begin
      mismatched++; $display("FAIL b2b_gap: hs=%0d reads=%0d gap=%0d want 2 2 2", hs_cycles.size(), rd_cycles.size(),
                             (rd_cycles.size() > 1 && hs_cycles.size() > 0) ? rd_cycles[1] - hs_cycles[0] : -1);
    end
    compared++;
    if (obs_cmds.size() != 2 || obs_cmds[0] != exp_cmds[0] || obs_cmds[1] != exp_cmds[1]) begin
      mismatched++; $display("FAIL b2b_decode: got %0d cmds want 2 matching", obs_cmds.size());
    end
  endtask

  task automatic test_random;
    bit ok;
    int r0, words, n;
    logic [31:0] w;
    for (int it = 0; it < 25; it++) begin
      clear_obs; r0 = n_rd; words = 0;
      ready_delay = $urandom_range(0, 3);
      n = $urandom_range(1, 3);
      @(posedge clk); #1;
      for (int k = 0; k < n; k++) begin
        w = $urandom;
        words += w[31] ? 2 : 1;
        push_cmd(w, $urandom);
      end
      wait_idle(600, ok);
      compared++;
      if (!ok || n_rd - r0 != words || obs_cmds.size() != exp_cmds.size()) begin
        mismatched++; $display("FAIL rand_flow it=%0d: reads=%0d cmds=%0d want %0d %0d", it, n_rd - r0,
                               obs_cmds.size(), words, exp_cmds.size());
      end
      for (int k = 0; k < obs_cmds.size() && k < exp_cmds.size(); k++) begin
        compared++;
        if (obs_cmds[k] != exp_cmds[k]) begin
          mismatched++; $display("FAIL rand_cmd it=%0d k=%0d: op=%h arg=%h opnd=%h want op=%h arg=%h opnd=%h", it, k,
                                 obs_cmds[k].op, obs_cmds[k].arg, obs_cmds[k].operand,
                                 exp_cmds[k].op, exp_cmds[k].arg, exp_cmds[k].operand);
        end
      end
      compared++;
      if (obs_wr.size() != exp_nwr || exp_wr.size() != exp_nwr || obs_wr != exp_wr || wr_unstable != 0) begin
        mismatched++; $display("FAIL rand_write it=%0d: writes=%0d want %0d unstable=%0d", it, obs_wr.size(), exp_nwr, wr_unstable);
      end
    end
    ready_delay = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    test_reset;
    test_no_operand;
    test_operand;
    test_response;
    test_timeout;
    test_backpressure;
    test_reset_midop;
    test_back_to_back;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/spi_cmd_engine.md
# spi_cmd_engine

Command engine that sits directly downstream of the SPI byte bridge. It pulls 32-bit words from the bridge's bus side and decodes them into commands for the controller core. It presents each command on a valid/ready port and, when the opcode requires one, returns a 32-bit response word to the host through the bridge's write path.

## Interface
Parameters:
- TIMEOUT_CYCLES, default 1024: maximum cycles to wait for an operand-word read response.
- TIMEOUT_W, default 11: width of the timeout counter; must satisfy 2^TIMEOUT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low; reset=0 asserts.
- rx_fifo_empty  in  1  bridge RX FIFO empty flag.
- bus_read  out  1  one-cycle read request to bridge.
- bus_read_response  in  1  bridge read done; may stay high for several cycles.
- bus_read_data  in  32  bridge read word; first SPI byte is in [31:24].
- bus_write  out  1  one-cycle write request to bridge.
- bus_write_response  in  1  bridge write done; may stay high for several cycles.
- bus_write_data  out  32  word to transmit; held stable from request until response.
- cmd_valid  out  1  command available.
- cmd_ready  in  1  core accepts command.
- cmd_opcode  out  8  command word [31:24].
- cmd_arg  out  24  command word [23:0].
- cmd_operand  out  32  operand word; 0 when none.
- cmd_has_operand  out  1  equals cmd_opcode[7].
- rsp_valid  in  1  core response available.
- rsp_ready  out  1  one-cycle accept of the response.
- rsp_data  in  32  core response word.
- err_timeout  out  1  one-cycle pulse on operand timeout.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- Opcode bit 7 set: one operand word follows the command word. Opcode bit 6 set: the core returns one response word. Other opcode bits are not interpreted here.
- Response detection: resp_q registers bus_read_response and bus_write_response. A response edge is response=1 while the registered copy is 0. Data is captured only on that edge, and a level held for several cycles counts once.
- States and transitions:
  - IDLE: when rx_fifo_empty=0, pulse bus_read and go to CMD_WAIT.
  - CMD_WAIT: on read-response edge, latch opcode/arg and go to CMD_DRAIN. No timeout applies in this state.
  - CMD_DRAIN: wait until bus_read_response=0. Then go to OP_WAIT if opcode[7]=1, pulsing bus_read and clearing the timer; otherwise go to ISSUE.
  - OP_WAIT: on read-response edge, latch the operand and go to OP_DRAIN. If the timer reaches TIMEOUT_CYCLES first, pulse err_timeout and go to IDLE, discarding the command.
  - OP_DRAIN: wait until bus_read_response=0, then go to ISSUE.
  - ISSUE: cmd_valid=1 with all cmd_* fields stable. When cmd_ready=1, go to RSP_WAIT if opcode[6]=1, else to IDLE.
  - RSP_WAIT: when rsp_valid=1, pulse rsp_ready, latch rsp_data into bus_write_data, pulse bus_write, and go to WR_WAIT.
  - WR_WAIT: on write-response edge, go to WR_DRAIN.
  - WR_DRAIN: wait until bus_write_response=0, then go to IDLE.
- A read-response edge in any state other than CMD_WAIT or OP_WAIT is ignored. This includes a late response that arrives after a timeout.
- Reset mid-operation returns the FSM to IDLE immediately and clears every output. The partial command is lost.

## Timing
- Reset values: all outputs 0, including bus_write_data and the cmd_* fields. State is IDLE, timer is 0, resp_q is 0.
- bus_read and bus_write are exactly one cycle wide, registered, and issued on the cycle after the state-entry decision.
- Capture latency: the data word is registered on the edge cycle and visible on cmd_* one cycle later.
- Minimum command-to-issue latency, measured from the CMD_WAIT edge to cmd_valid=1, is 2 cycles plus the drain time.
- cmd_valid stays high until the handshake cycle and drops the cycle after it. cmd_* fields stay unchanged until the next capture.
- The timer increments once per cycle in OP_WAIT and saturates at TIMEOUT_CYCLES. err_timeout fires in the cycle the count equals TIMEOUT_CYCLES.
- rx_fifo_empty is sampled only in IDLE. At most one bus request is outstanding at any time.
- Back-to-back commands: IDLE re-evaluates rx_fifo_empty one cycle after returning to IDLE.

## Test plan
- No-operand, no-response command: bridge returns 0x01ABCDEF with response held for 2 cycles. Required: one bus_read; cmd_opcode=0x01, cmd_arg=0xABCDEF, cmd_operand=0, cmd_has_operand=0; one cmd_valid handshake; return to IDLE; no bus_write.
- Operand command: bridge returns 0x80000010, then 0xDEADBEEF. Required: exactly two bus_read pulses; cmd_operand=0xDEADBEEF; cmd_has_operand=1.
- Response path: opcode 0x40 is issued and the core later drives rsp_data=0x12345678. Required: one rsp_ready pulse; one bus_write with bus_write_data=0x12345678 held until bus_write_response; busy=0 after the drain.
- Operand timeout with TIMEOUT_CYCLES=16: the operand response never arrives. Required: err_timeout pulses once, 16 cycles after entering OP_WAIT; no cmd_valid; a response arriving after the timeout is ignored.
- Backpressure: cmd_ready is held 0 for 20 cycles. Required: cmd_valid and all fields stay stable, with exactly one acceptance.
- Reset (reset=0) asserted asynchronously in OP_WAIT and again in WR_WAIT. Required: all outputs 0 immediately; after release, the next command decodes correctly.
